fft_stream_checker: RTL and testbench

Parametrised, synthesizable output checker for the FFT core. It replaces the ad-hoc SNR and latency checking in the simulation bench with a reusable block usable in simulation, emulation and FPGA bring-up. After an arm pulse it consumes one frame of DUT output samples and the matching golden samples, which are fetched through a gold-index port. It accumulates signal and noise energy, measures latency against a limit, and reports pass, fail or timeout per frame, plus running pass and fail counts.

---
 rtl/fft_stream_checker.sv | 190 +++++++++++++++++++
 tb/tb_fft_stream_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_stream_checker.sv
// Streaming output checker for the FFT core: after an arm pulse it consumes one
// frame of DUT samples alongside golden samples, accumulates signal and noise
// energy, tracks latency against a limit and reports pass/fail/timeout.
module fft_stream_checker #(
    parameter int N         = 32,
    parameter int OUT_W     = 16,
    parameter int GOLD_W    = 17,
    parameter int ACC_W     = 48,
    parameter int LAT_LIMIT = 68,
    parameter int SNR_RATIO = 10000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     dut_valid,
    input  logic signed [OUT_W-1:0]  dut_r,
    input  logic signed [OUT_W-1:0]  dut_i,
    input  logic signed [GOLD_W-1:0] gold_r,
    input  logic signed [GOLD_W-1:0] gold_i,
    output logic [$clog2(N)-1:0]     gold_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic                     overflow,
    output logic                     stray,
    output logic [ACC_W-1:0]         sig_energy,
    output logic [ACC_W-1:0]         noise_energy,
    output logic [7:0]               latency,
    output logic [7:0]               pass_cnt,
    output logic [7:0]               fail_cnt
);
    localparam int IDX_W  = $clog2(N);
    localparam int SQ_W   = 2 * GOLD_W + 2;
    // One spare bit above the larger of accumulator and term so the sum never wraps.
    localparam int SUM_W  = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
    localparam int PROD_W = ACC_W + 32;

    typedef enum logic [1:0] {IDLE, WAIT, COLLECT, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ACC_W-1:0]   sig_q, sig_d, noise_q, noise_d;
    logic [7:0]         lat_q, lat_d, pcnt_q, pcnt_d, fcnt_q, fcnt_d;
    logic               pass_q, pass_d, to_q, to_d, ovf_q, ovf_d;
    logic               stray_q, stray_d, done_q, done_d;

    logic signed [GOLD_W:0]     gr_x, gi_x, dr_x, di_x, er, ei;
    logic signed [SQ_W-1:0]     er2, ei2, gr2, gi2;
    logic [SQ_W-1:0]            noise_term, sig_term;
    logic [SUM_W-1:0]           noise_sum, sig_sum, acc_max;
    logic [7:0]                 lat_inc;
    logic                       lat_over, finish;
    logic [PROD_W-1:0]          prod, sig_ext;

    // Next-state, datapath and result evaluation for one cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sig_d   = sig_q;
        noise_d = noise_q;
        lat_d   = lat_q;
        pass_d  = pass_q;
        to_d    = to_q;
        ovf_d   = ovf_q;
        stray_d = stray_q;
        pcnt_d  = pcnt_q;
        fcnt_d  = fcnt_q;
        done_d  = 1'b0;
        finish  = 1'b0;
        prod    = '0;
        sig_ext = '0;

        // Errors at GOLD_W+1 bits so gold - dut can never wrap.
        gr_x = {gold_r[GOLD_W-1], gold_r};
        gi_x = {gold_i[GOLD_W-1], gold_i};
        dr_x = {{(GOLD_W + 1 - OUT_W){dut_r[OUT_W-1]}}, dut_r};
        di_x = {{(GOLD_W + 1 - OUT_W){dut_i[OUT_W-1]}}, dut_i};
        er   = gr_x - dr_x;
        ei   = gi_x - di_x;
        er2  = er * er;
        ei2  = ei * ei;
        gr2  = gr_x * gr_x;
        gi2  = gi_x * gi_x;
        noise_term = $unsigned(er2) + $unsigned(ei2);
        sig_term   = $unsigned(gr2) + $unsigned(gi2);
        acc_max    = SUM_W'({ACC_W{1'b1}});
        noise_sum  = SUM_W'(noise_q) + SUM_W'(noise_term);
        sig_sum    = SUM_W'(sig_q) + SUM_W'(sig_term);

        lat_inc  = (lat_q == 8'hFF) ? 8'hFF : lat_q + 8'd1;
        lat_over = 32'(lat_inc) > 32'(LAT_LIMIT);

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = WAIT;
                    idx_d   = '0;
                    sig_d   = '0;
                    noise_d = '0;
                    lat_d   = '0;
                    pass_d  = 1'b0;
                    to_d    = 1'b0;
                    ovf_d   = 1'b0;
                    stray_d = 1'b0;
                end else if (dut_valid) begin
                    stray_d = 1'b1;
                end
            end
            WAIT, COLLECT: begin
                lat_d = lat_inc;
                if (lat_over) begin
                    // Late sample in the expiring cycle is deliberately dropped.
                    to_d   = 1'b1;
                    finish = 1'b1;
                end else if (dut_valid) begin
                    noise_d = (noise_sum > acc_max) ? {ACC_W{1'b1}} : noise_sum[ACC_W-1:0];
                    sig_d   = (sig_sum > acc_max) ? {ACC_W{1'b1}} : sig_sum[ACC_W-1:0];
                    ovf_d   = ovf_q | (noise_sum > acc_max) | (sig_sum > acc_max);
                    idx_d   = idx_q + 1'b1;
                    state_d = COLLECT;
                    finish  = (idx_q == IDX_W'(N - 1));
                end
            end
            DONE: begin
                state_d = IDLE;
                if (dut_valid) stray_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Result is evaluated on entry to DONE so done and pass appear together.
        if (finish) begin
            state_d = DONE;
            done_d  = 1'b1;
            prod    = PROD_W'(noise_d) * PROD_W'(SNR_RATIO);
            sig_ext = PROD_W'(sig_d);
            pass_d  = !to_d && !ovf_d && ((noise_d == '0) || (sig_ext >= prod));
            if (pass_d) begin
                if (pcnt_q != 8'hFF) pcnt_d = pcnt_q + 8'd1;
            end else begin
                if (fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    // State register with asynchronous clear; a reset mid-frame simply abandons it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sig_q   <= '0;
            noise_q <= '0;
            lat_q   <= '0;
            pass_q  <= 1'b0;
            to_q    <= 1'b0;
            ovf_q   <= 1'b0;
            stray_q <= 1'b0;
            done_q  <= 1'b0;
            pcnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sig_q   <= sig_d;
            noise_q <= noise_d;
            lat_q   <= lat_d;
            pass_q  <= pass_d;
            to_q    <= to_d;
            ovf_q   <= ovf_d;
            stray_q <= stray_d;
            done_q  <= done_d;
            pcnt_q  <= pcnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign gold_idx     = idx_q;
    assign busy         = (state_q == WAIT) || (state_q == COLLECT);
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout      = to_q;
    assign overflow     = ovf_q;
    assign stray        = stray_q;
    assign sig_energy   = sig_q;
    assign noise_energy = noise_q;
    assign latency      = lat_q;
    assign pass_cnt     = pcnt_q;
    assign fail_cnt     = fcnt_q;
endmodule

// File: tb/tb_fft_stream_checker.sv
// Scoreboard bench for fft_stream_checker: each frame's expected result is
// modelled while stimulus is driven and compared when done pulses.
module tb_fft_stream_checker;
    localparam int N = 32, OUT_W = 16, GOLD_W = 17, ACC_W = 48, LIM = 68, RATIO = 10000;

    logic clk = 0, reset = 1, arm = 0, dut_valid = 0;
    logic signed [OUT_W-1:0]  dut_r = 0, dut_i = 0;
    logic signed [GOLD_W-1:0] gold_r, gold_i;
    logic [4:0] gold_idx;
    logic busy, done, pass, timeout, overflow, stray;
    logic [ACC_W-1:0] sig_energy, noise_energy;
    logic [7:0] latency, pass_cnt, fail_cnt;

    logic signed [GOLD_W-1:0] tab_r [N];
    logic signed [GOLD_W-1:0] tab_i [N];
    assign gold_r = tab_r[gold_idx];
    assign gold_i = tab_i[gold_idx];

    fft_stream_checker #(.N(N), .OUT_W(OUT_W), .GOLD_W(GOLD_W), .ACC_W(ACC_W),
                         .LAT_LIMIT(LIM), .SNR_RATIO(RATIO)) dut (
        .clk(clk), .reset(reset), .arm(arm), .dut_valid(dut_valid),
        .dut_r(dut_r), .dut_i(dut_i), .gold_r(gold_r), .gold_i(gold_i),
        .gold_idx(gold_idx), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .overflow(overflow), .stray(stray),
        .sig_energy(sig_energy), .noise_energy(noise_energy), .latency(latency),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt));

    always #5 clk = ~clk;

    typedef struct {
        bit     ps;
        bit     to;
        longint sig;
        longint noise;
        int     lat;
        int     pc;
        int     fc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0, checks = 0, frames_done = 0;
    int   pc = 0, fc = 0;
    logic done_prev = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Pop and compare one expected frame result per done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (done && done_prev) chk("done_width", 2, 1);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pass", longint'(pass), longint'(e.ps));
                    chk("timeout", longint'(timeout), longint'(e.to));
                    chk("overflow", longint'(overflow), 0);
                    chk("sig_energy", longint'(sig_energy), e.sig);
                    chk("noise_energy", longint'(noise_energy), e.noise);
                    chk("latency", longint'(latency), longint'(e.lat));
                    chk("pass_cnt", longint'(pass_cnt), longint'(e.pc));
                    chk("fail_cnt", longint'(fail_cnt), longint'(e.fc));
                    chk("busy_at_done", longint'(busy), 0);
                    $display("frame %0d: pass=%0d to=%0d sig=%0d noise=%0d lat=%0d pc=%0d fc=%0d",
                             frames_done, pass, timeout, sig_energy, noise_energy, latency,
                             pass_cnt, fail_cnt);
                end
                frames_done++;
            end
            done_prev = done;
        end else begin
            done_prev = 0;
        end
    end

    task automatic fill_const(input int re, input int im);
        for (int i = 0; i < N; i++) begin
            tab_r[i] = GOLD_W'(re);
            tab_i[i] = GOLD_W'(im);
        end
    endtask

    task automatic wait_done(input int seen);
        int k = 0;
        while (frames_done == seen && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (frames_done == seen) chk("done_timeout", 0, 1);
    endtask

    // Drive one armed frame and model its result; arm2_at re-arms at that sample.
    task automatic run_frame(input int pre_gap, input bit alt, input int err_idx,
                             input int err_off, input int arm2_at, input bit chk_idx);
        int lat = 0, cnt = 0, seen;
        longint s = 0, n = 0, tr, ti, dr;
        bit to = 0, v;
        exp_t e;
        seen = frames_done;
        @(negedge clk);
        arm = 1;
        @(negedge clk);
        arm = 0;
        chk("busy_after_arm", longint'(busy), 1);
        chk("stray_after_arm", longint'(stray), 0);
        while (1) begin
            lat++;
            v = (lat > pre_gap) && (!alt || (((lat - pre_gap) % 2) == 1));
            dut_valid = v;
            arm = (v && cnt == arm2_at);
            if (v) begin
                tr = longint'(tab_r[cnt]);
                ti = longint'(tab_i[cnt]);
                dr = tr - ((cnt == err_idx) ? err_off : 0);
                dut_r = OUT_W'(dr);
                dut_i = OUT_W'(ti);
                if (chk_idx) chk("gold_idx_step", longint'(gold_idx), cnt);
            end
            if (lat > LIM) begin
                to = 1;
            end else if (v) begin
                s += tr * tr + ti * ti;
                n += (tr - dr) * (tr - dr);
                cnt++;
            end
            @(negedge clk);
            if (to || cnt == N) break;
        end
        dut_valid = 0;
        arm = 0;
        e.ps = !to && (n == 0 || s >= longint'(RATIO) * n);
        if (e.ps) pc++; else fc++;
        e.to = to; e.sig = s; e.noise = n; e.lat = lat; e.pc = pc; e.fc = fc;
        exp_q.push_back(e);
        wait_done(seen);
    endtask

    initial begin
        fill_const(1000, 0);
        repeat (3) @(negedge clk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_pass_cnt", longint'(pass_cnt), 0);
        reset = 0;
        @(negedge clk);
        chk("idle_gold_idx", longint'(gold_idx), 0);

        run_frame(0, 0, -1, 0, -1, 0);     // clean, consecutive
        run_frame(0, 0, 5, 100, -1, 0);    // ratio 3200 -> fail
        run_frame(0, 0, 5, 10, -1, 0);     // ratio 320000 -> pass
        run_frame(40, 0, -1, 0, -1, 0);    // timeout at latency 69
        run_frame(0, 1, -1, 0, -1, 1);     // alternate cycles, latency 63
        chk("gold_idx_wrap", longint'(gold_idx), 0);

        for (int i = 0; i < N; i++) begin
            tab_r[i] = GOLD_W'(i * 300 - 4000);
            tab_i[i] = GOLD_W'(2000 - i * 125);
        end
        run_frame(0, 0, N - 1, -7, -1, 0); // error on the very last sample
        fill_const(1000, 0);

        // Reset mid-frame after 10 accepted samples.
        @(negedge clk);
        arm = 1;
        @(negedge clk);
        arm = 0;
        dut_r = 1000;
        dut_i = 0;
        dut_valid = 1;
        repeat (10) @(negedge clk);
        dut_valid = 0;
        reset = 1;
        @(negedge clk);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_sig", longint'(sig_energy), 0);
        chk("mid_rst_lat", longint'(latency), 0);
        chk("mid_rst_idx", longint'(gold_idx), 0);
        chk("mid_rst_cnts", longint'(pass_cnt) + longint'(fail_cnt), 0);
        reset = 0;
        pc = 0;
        fc = 0;
        run_frame(0, 0, -1, 0, -1, 0);

        // Stray sample in IDLE, then a frame that clears it and ignores a re-arm.
        @(negedge clk);
        dut_valid = 1;
        @(negedge clk);
        dut_valid = 0;
        chk("stray_set", longint'(stray), 1);
        chk("stray_pass_cnt", longint'(pass_cnt), pc);
        chk("stray_sig", longint'(sig_energy), 32000000);
        run_frame(0, 0, -1, 0, 10, 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
